// File: rtl/sqrt_arbiter.sv
// Round-robin arbiter that time-shares one combinational integer square-root
// unit between NUM_REQ requesters and returns each result tagged with its owner.
module sqrt_arbiter #(
  parameter int unsigned NUM_REQ  = 4,
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned SQRT_LAT = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [NUM_REQ*WIDTH-1:0]   req_data,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic                       resp_valid,
  input  logic                       resp_ready,
  output logic [WIDTH-1:0]           resp_data,
  output logic [$clog2(NUM_REQ)-1:0] resp_id,
  output logic [WIDTH-1:0]           sqrt_in,
  input  logic [WIDTH-1:0]           sqrt_out,
  output logic                       busy
);

  localparam int unsigned IdW  = $clog2(NUM_REQ);
  localparam int unsigned CntW = $clog2(SQRT_LAT + 1);

  typedef enum logic [1:0] {StIdle, StHold, StResp} state_t;

  state_t            r_state;
  state_t            w_state_next;
  logic [IdW-1:0]    r_last_grant;
  logic [IdW-1:0]    r_grant_id;
  logic [WIDTH-1:0]  r_operand;
  logic [CntW-1:0]   r_cnt;
  logic [WIDTH-1:0]  r_resp_data;
  logic [IdW-1:0]    r_resp_id;
  logic              r_resp_valid;

  logic              w_any;
  logic [IdW-1:0]    w_winner;
  int unsigned       w_idx;
  logic [WIDTH-1:0]  w_sel_data;
  logic              w_accept;
  logic              w_done;
  logic              w_handshake;

  // Round-robin search: first valid index after the last grant, wrapping.
  always_comb begin
    w_any    = 1'b0;
    w_winner = '0;
    w_idx    = 0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      w_idx = (32'(r_last_grant) + k) % NUM_REQ;
      if (!w_any && req_valid[IdW'(w_idx)]) begin
        w_any    = 1'b1;
        w_winner = IdW'(w_idx);
      end
    end
  end

  // Operand mux for the winning requester.
  always_comb begin
    w_sel_data = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (w_winner == IdW'(i)) begin
        w_sel_data = req_data[i*WIDTH +: WIDTH];
      end
    end
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state decode and grant; req_ready is forced low while reset is held.
  always_comb begin
    w_state_next = r_state;
    req_ready    = '0;
    w_accept     = 1'b0;
    w_done       = 1'b0;
    w_handshake  = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (w_any && !rst) begin
          req_ready    = NUM_REQ'(1) << w_winner;
          w_accept     = 1'b1;
          w_state_next = StHold;
        end
      end
      StHold: begin
        if (r_cnt == CntW'(1)) begin
          w_done       = 1'b1;
          w_state_next = StResp;
        end
      end
      StResp: begin
        // No grant in the handshake cycle: one idle bubble per operation.
        if (r_resp_valid && resp_ready) begin
          w_handshake  = 1'b1;
          w_state_next = StIdle;
        end
      end
      default: w_state_next = StIdle;
    endcase
  end

  // Datapath: operand capture, settle counter, result register, priority pointer.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_last_grant <= IdW'(NUM_REQ - 1);
      r_grant_id   <= '0;
      r_operand    <= '0;
      r_cnt        <= '0;
      r_resp_data  <= '0;
      r_resp_id    <= '0;
      r_resp_valid <= 1'b0;
    end else begin
      if (w_accept) begin
        r_operand  <= w_sel_data;
        r_grant_id <= w_winner;
        r_cnt      <= CntW'(SQRT_LAT);
      end else if (r_state == StHold) begin
        r_cnt <= r_cnt - CntW'(1);
      end
      if (w_done) begin
        r_resp_data  <= sqrt_out;
        r_resp_id    <= r_grant_id;
        r_resp_valid <= 1'b1;
      end
      if (w_handshake) begin
        r_resp_valid <= 1'b0;
        r_last_grant <= r_grant_id;
      end
    end
  end

  // sqrt_in keeps the last operand after completion to avoid toggling the shared unit.
  assign sqrt_in    = r_operand;
  assign resp_valid = r_resp_valid;
  assign resp_data  = r_resp_data;
  assign resp_id    = r_resp_id;
  assign busy       = (r_state != StIdle);

endmodule

// File: tb/tb_sqrt_arbiter.sv
// Directed bench for sqrt_arbiter: a SQRT_LAT=1 instance for arbitration,
// throughput and backpressure, and a SQRT_LAT=4 instance for reset-in-HOLD.
module tb_sqrt_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_pass   = 0;

  // Environment model of the shared sqrt unit.
  function automatic logic [31:0] isqrt(input logic [31:0] x);
    logic [31:0] r;
    logic [31:0] t;
    r = '0;
    for (int b = 15; b >= 0; b--) begin
      t = r | (32'd1 << b);
      if (({32'd0, t} * {32'd0, t}) <= {32'd0, x}) r = t;
    end
    return r;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
  endtask

  // Instance A: SQRT_LAT = 1
  logic         a_rst;
  logic [3:0]   a_req_valid;
  logic [127:0] a_req_data;
  logic [3:0]   a_req_ready;
  logic         a_resp_valid;
  logic         a_resp_ready;
  logic [31:0]  a_resp_data;
  logic [1:0]   a_resp_id;
  logic [31:0]  a_sqrt_in;
  logic [31:0]  a_sqrt_out;
  logic         a_busy;

  assign a_sqrt_out = isqrt(a_sqrt_in);

  sqrt_arbiter #(.NUM_REQ(4), .WIDTH(32), .SQRT_LAT(1)) u_dut_a (
    .clk        (clk),
    .rst        (a_rst),
    .req_valid  (a_req_valid),
    .req_data   (a_req_data),
    .req_ready  (a_req_ready),
    .resp_valid (a_resp_valid),
    .resp_ready (a_resp_ready),
    .resp_data  (a_resp_data),
    .resp_id    (a_resp_id),
    .sqrt_in    (a_sqrt_in),
    .sqrt_out   (a_sqrt_out),
    .busy       (a_busy)
  );

  // Instance B: SQRT_LAT = 4
  logic         b_rst;
  logic [3:0]   b_req_valid;
  logic [127:0] b_req_data;
  logic [3:0]   b_req_ready;
  logic         b_resp_valid;
  logic         b_resp_ready;
  logic [31:0]  b_resp_data;
  logic [1:0]   b_resp_id;
  logic [31:0]  b_sqrt_in;
  logic [31:0]  b_sqrt_out;
  logic         b_busy;

  assign b_sqrt_out = isqrt(b_sqrt_in);

  sqrt_arbiter #(.NUM_REQ(4), .WIDTH(32), .SQRT_LAT(4)) u_dut_b (
    .clk        (clk),
    .rst        (b_rst),
    .req_valid  (b_req_valid),
    .req_data   (b_req_data),
    .req_ready  (b_req_ready),
    .resp_valid (b_resp_valid),
    .resp_ready (b_resp_ready),
    .resp_data  (b_resp_data),
    .resp_id    (b_resp_id),
    .sqrt_in    (b_sqrt_in),
    .sqrt_out   (b_sqrt_out),
    .busy       (b_busy)
  );

  typedef struct {
    logic [3:0]   mask;
    logic [127:0] data;
    logic [3:0]   exp_ready;
    logic [1:0]   exp_id;
    logic [31:0]  exp_op;
    logic [31:0]  exp_res;
    bit           chk_gap;
  } vec_t;

  vec_t vecs[11];

  // Bounded wait for a grant on instance A; returns the cycle it appeared.
  task automatic a_wait_grant(output int gcyc);
    int n;
    n = 0;
    while (a_req_ready == 4'b0 && n < 10) begin
      @(negedge clk);
      #1;
      n++;
    end
    gcyc = cyc;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int   g;
    int   prev_g;
    bit   seen;

    // All four valid from reset: grant order 0,1,2,3.
    vecs[0]  = '{4'b1111, {32'hFFFF_FFFF, 32'd99, 32'd1, 32'd0}, 4'b0001, 2'd0, 32'd0, 32'd0, 1'b0};
    vecs[1]  = '{4'b1111, {32'hFFFF_FFFF, 32'd99, 32'd1, 32'd0}, 4'b0010, 2'd1, 32'd1, 32'd1, 1'b1};
    vecs[2]  = '{4'b1111, {32'hFFFF_FFFF, 32'd99, 32'd1, 32'd0}, 4'b0100, 2'd2, 32'd99, 32'd9, 1'b1};
    vecs[3]  = '{4'b1111, {32'hFFFF_FFFF, 32'd99, 32'd1, 32'd0}, 4'b1000, 2'd3, 32'hFFFF_FFFF,
                 32'd65535, 1'b1};
    // Requesters 0 and 2 held valid: 0,2,0,2.
    vecs[4]  = '{4'b0101, {32'd0, 32'd81, 32'd0, 32'd16}, 4'b0001, 2'd0, 32'd16, 32'd4, 1'b1};
    vecs[5]  = '{4'b0101, {32'd0, 32'd81, 32'd0, 32'd16}, 4'b0100, 2'd2, 32'd81, 32'd9, 1'b1};
    vecs[6]  = '{4'b0101, {32'd0, 32'd81, 32'd0, 32'd16}, 4'b0001, 2'd0, 32'd16, 32'd4, 1'b1};
    vecs[7]  = '{4'b0101, {32'd0, 32'd81, 32'd0, 32'd16}, 4'b0100, 2'd2, 32'd81, 32'd9, 1'b1};
    // Single requester 1.
    vecs[8]  = '{4'b0010, {32'd0, 32'd0, 32'd100, 32'd0}, 4'b0010, 2'd1, 32'd100, 32'd10, 1'b1};
    // Wrap: from last_grant=1 search 2,3 -> 3; then 0.
    vecs[9]  = '{4'b1001, {32'd144, 32'd0, 32'd0, 32'd7}, 4'b1000, 2'd3, 32'd144, 32'd12, 1'b1};
    vecs[10] = '{4'b1001, {32'd144, 32'd0, 32'd0, 32'd7}, 4'b0001, 2'd0, 32'd7, 32'd2, 1'b1};

    a_rst = 1'b1; a_req_valid = '0; a_req_data = '0; a_resp_ready = 1'b0;
    b_rst = 1'b1; b_req_valid = '0; b_req_data = '0; b_resp_ready = 1'b0;
    prev_g = 0;

    #12;
    chk("rst_resp_valid", 64'(a_resp_valid), 64'd0);
    chk("rst_req_ready", 64'(a_req_ready), 64'd0);
    chk("rst_busy", 64'(a_busy), 64'd0);
    chk("rst_sqrt_in", 64'(a_sqrt_in), 64'd0);
    chk("rst_resp_data", 64'(a_resp_data), 64'd0);
    chk("rst_resp_id", 64'(a_resp_id), 64'd0);
    chk("b_rst_busy", 64'(b_busy), 64'd0);
    @(negedge clk);
    a_rst = 1'b0;

    // Table-driven operations with resp_ready held high.
    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      a_req_valid  = vecs[i].mask;
      a_req_data   = vecs[i].data;
      a_resp_ready = 1'b1;
      #1;
      a_wait_grant(g);
      chk($sformatf("v%0d_grant", i), 64'(a_req_ready), 64'(vecs[i].exp_ready));
      if (vecs[i].chk_gap) chk($sformatf("v%0d_gap", i), 64'(g - prev_g), 64'd3);
      prev_g = g;
      @(negedge clk);
      #1;
      chk($sformatf("v%0d_hold_valid", i), 64'(a_resp_valid), 64'd0);
      chk($sformatf("v%0d_sqrt_in", i), 64'(a_sqrt_in), 64'(vecs[i].exp_op));
      chk($sformatf("v%0d_busy", i), 64'(a_busy), 64'd1);
      @(negedge clk);
      #1;
      chk($sformatf("v%0d_resp_valid", i), 64'(a_resp_valid), 64'd1);
      chk($sformatf("v%0d_resp_data", i), 64'(a_resp_data), 64'(vecs[i].exp_res));
      chk($sformatf("v%0d_resp_id", i), 64'(a_resp_id), 64'(vecs[i].exp_id));
    end

    // Backpressure: last_grant=0, requester 1 with 49, consumer stalls 5 cycles.
    @(negedge clk);
    a_req_valid  = 4'b0010;
    a_req_data   = {32'd0, 32'd81, 32'd49, 32'd16};
    a_resp_ready = 1'b0;
    #1;
    a_wait_grant(g);
    chk("bp_grant", 64'(a_req_ready), 64'b0010);
    @(negedge clk);
    a_req_valid = 4'b0101;
    #1;
    chk("bp_hold_ready", 64'(a_req_ready), 64'd0);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      #1;
      chk($sformatf("bp%0d_valid", k), 64'(a_resp_valid), 64'd1);
      chk($sformatf("bp%0d_data", k), 64'(a_resp_data), 64'd7);
      chk($sformatf("bp%0d_id", k), 64'(a_resp_id), 64'd1);
      chk($sformatf("bp%0d_ready", k), 64'(a_req_ready), 64'd0);
    end
    a_resp_ready = 1'b1;
    #1;
    chk("bp_hs_ready", 64'(a_req_ready), 64'd0);
    @(negedge clk);
    #1;
    chk("bp_after_valid", 64'(a_resp_valid), 64'd0);
    chk("bp_next_grant", 64'(a_req_ready), 64'b0100);
    @(negedge clk);
    a_req_valid = 4'b0000;
    @(negedge clk);
    #1;
    chk("bp_next_data", 64'(a_resp_data), 64'd9);
    chk("bp_next_id", 64'(a_resp_id), 64'd2);

    // Asynchronous reset while holding a response.
    @(negedge clk);
    a_req_valid  = 4'b0001;
    a_req_data   = {32'd0, 32'd0, 32'd0, 32'd36};
    a_resp_ready = 1'b0;
    #1;
    a_wait_grant(g);
    chk("ar_grant", 64'(a_req_ready), 64'b0001);
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("ar_pre_valid", 64'(a_resp_valid), 64'd1);
    chk("ar_pre_data", 64'(a_resp_data), 64'd6);
    #2;
    a_rst = 1'b1;
    #1;
    chk("ar_resp_valid", 64'(a_resp_valid), 64'd0);
    chk("ar_req_ready", 64'(a_req_ready), 64'd0);
    chk("ar_busy", 64'(a_busy), 64'd0);
    chk("ar_sqrt_in", 64'(a_sqrt_in), 64'd0);
    chk("ar_resp_data", 64'(a_resp_data), 64'd0);
    @(negedge clk);
    a_rst = 1'b0;
    #1;
    chk("ar_post_grant", 64'(a_req_ready), 64'b0001);
    a_req_valid = 4'b0000;

    // Instance B: reset during the 2nd HOLD cycle abandons the operation.
    @(negedge clk);
    b_rst        = 1'b0;
    b_req_valid  = 4'b1000;
    b_req_data   = {32'd64, 32'd0, 32'd0, 32'd25};
    b_resp_ready = 1'b1;
    #1;
    chk("b_grant3", 64'(b_req_ready), 64'b1000);
    @(negedge clk);
    b_req_valid = 4'b0000;
    #1;
    chk("b_hold_busy", 64'(b_busy), 64'd1);
    chk("b_hold_sqrt_in", 64'(b_sqrt_in), 64'd64);
    @(negedge clk);
    #2;
    b_rst = 1'b1;
    #1;
    chk("b_rst_busy2", 64'(b_busy), 64'd0);
    chk("b_rst_sqrt_in", 64'(b_sqrt_in), 64'd0);
    chk("b_rst_valid", 64'(b_resp_valid), 64'd0);
    @(negedge clk);
    b_rst = 1'b0;
    seen  = 1'b0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      #1;
      if (b_resp_valid) seen = 1'b1;
    end
    chk("b_no_resp", 64'(seen), 64'd0);
    b_req_valid = 4'b1001;
    #1;
    chk("b_prio0", 64'(b_req_ready), 64'b0001);
    @(negedge clk);
    b_req_valid = 4'b0000;
    for (int k = 1; k <= 4; k++) begin
      if (k > 1) @(negedge clk);
      #1;
      chk($sformatf("b_lat%0d", k), 64'(b_resp_valid), 64'd0);
    end
    @(negedge clk);
    #1;
    chk("b_resp_valid", 64'(b_resp_valid), 64'd1);
    chk("b_resp_data", 64'(b_resp_data), 64'd5);
    chk("b_resp_id", 64'(b_resp_id), 64'd0);

    @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
